// File: rtl/hazard_unit.sv
// Pipeline hazard controller: load-use stalls, taken-branch flushes, and the
// freeze/launch/timeout sequencing around the multi-cycle WOS-filter unit.
module hazard_unit #(
  parameter int MC_TIMEOUT = 4096
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [4:0]  i_rs1_d,
  input  logic [4:0]  i_rs2_d,
  input  logic        i_rs1_used_d,
  input  logic        i_rs2_used_d,
  input  logic [4:0]  i_rd_e,
  input  logic        i_w_en_e,
  input  logic        i_mem_rd_e,
  input  logic        i_mc_start_e,
  input  logic        i_mc_done,
  input  logic        i_branch_taken_e,
  output logic        o_stall_f,
  output logic        o_stall_d,
  output logic        o_stall_e,
  output logic        o_flush_d,
  output logic        o_flush_e,
  output logic        o_flush_m,
  output logic        o_mc_go,
  output logic        o_mc_err,
  output logic [1:0]  o_state,
  output logic [15:0] o_stall_cnt
);

  typedef enum logic [1:0] {
    RUN     = 2'b00,
    MC_WAIT = 2'b01,
    MC_ERR  = 2'b10,
    ST_BAD  = 2'b11
  } state_t;

  localparam logic [15:0] TIMEOUT_LAST = 16'(MC_TIMEOUT - 1);

  state_t      state_q, state_d;
  logic [15:0] wait_cnt_q;
  logic [15:0] stall_cnt_q;
  logic        mc_go_q;
  logic        mc_err_q;
  logic        load_use;
  logic        done_counted;
  logic        timeout_hit;

  // Launch handshake: o_mc_go is a one-cycle request issued in the first
  // MC_WAIT cycle; i_mc_done is only accepted in MC_WAIT after that cycle.
  always_comb begin
    load_use = i_mem_rd_e && i_w_en_e && (i_rd_e != 5'd0) &&
               ((i_rs1_used_d && (i_rs1_d == i_rd_e)) ||
                (i_rs2_used_d && (i_rs2_d == i_rd_e)));
    done_counted = (state_q == MC_WAIT) && i_mc_done && !mc_go_q;
    timeout_hit  = (state_q == MC_WAIT) && !done_counted &&
                   (wait_cnt_q == TIMEOUT_LAST);
  end

  always_comb begin
    state_d   = state_q;
    o_stall_f = 1'b0;
    o_stall_d = 1'b0;
    o_stall_e = 1'b0;
    o_flush_d = 1'b0;
    o_flush_e = 1'b0;
    o_flush_m = 1'b0;
    if (!i_rst) begin
      case (state_q)
        RUN: begin
          if (i_mc_start_e) begin
            o_stall_f = 1'b1;
            o_stall_d = 1'b1;
            o_stall_e = 1'b1;
            o_flush_m = 1'b1;
            state_d   = MC_WAIT;
          end else if (i_branch_taken_e) begin
            o_flush_d = 1'b1;
            o_flush_e = 1'b1;
          end else if (load_use) begin
            o_stall_f = 1'b1;
            o_stall_d = 1'b1;
            o_flush_e = 1'b1;
          end
        end
        MC_WAIT: begin
          if (done_counted) begin
            state_d = RUN;
          end else begin
            o_stall_f = 1'b1;
            o_stall_d = 1'b1;
            o_stall_e = 1'b1;
            o_flush_m = 1'b1;
            if (timeout_hit) state_d = MC_ERR;
          end
        end
        MC_ERR: begin
          o_stall_f = 1'b1;
          o_stall_d = 1'b1;
          o_stall_e = 1'b1;
          o_flush_m = 1'b1;
        end
        default: state_d = RUN;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= RUN;
      mc_go_q     <= 1'b0;
      mc_err_q    <= 1'b0;
      wait_cnt_q  <= 16'd0;
      stall_cnt_q <= 16'd0;
    end else begin
      state_q  <= state_d;
      mc_go_q  <= (state_q == RUN) && i_mc_start_e;
      mc_err_q <= (state_d == MC_ERR);
      // Zero outside MC_WAIT so the count starts fresh on every entry.
      if (state_q == MC_WAIT) wait_cnt_q <= wait_cnt_q + 16'd1;
      else                    wait_cnt_q <= 16'd0;
      if (o_stall_f && (stall_cnt_q != 16'hFFFF))
        stall_cnt_q <= stall_cnt_q + 16'd1;
    end
  end

  assign o_mc_go     = mc_go_q;
  assign o_mc_err    = mc_err_q;
  assign o_state     = state_q;
  assign o_stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_hazard_unit.sv
// Bench for hazard_unit: directed hazard scenarios plus random traffic,
// checked per cycle against a behavioural model through an expected queue.
module tb_hazard_unit;

  localparam int TIMEOUT = 8;
  localparam int W = 26;

  typedef struct packed {
    logic       rst;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       rs1_used;
    logic       rs2_used;
    logic [4:0] rd;
    logic       w_en;
    logic       mem_rd;
    logic       mc_start;
    logic       mc_done;
    logic       branch;
  } stim_t;

  logic        i_clk;
  logic        i_rst;
  logic [4:0]  i_rs1_d, i_rs2_d, i_rd_e;
  logic        i_rs1_used_d, i_rs2_used_d;
  logic        i_w_en_e, i_mem_rd_e, i_mc_start_e, i_mc_done, i_branch_taken_e;
  logic        o_stall_f, o_stall_d, o_stall_e;
  logic        o_flush_d, o_flush_e, o_flush_m;
  logic        o_mc_go, o_mc_err;
  logic [1:0]  o_state;
  logic [15:0] o_stall_cnt;

  logic [W-1:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Model state: mode uses the architectural state codes directly.
  int m_mode   = 0;
  int m_waited = 0;
  bit m_go     = 0;
  bit m_err    = 0;
  int m_stalls = 0;

  hazard_unit #(.MC_TIMEOUT(TIMEOUT)) dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_rs1_d(i_rs1_d), .i_rs2_d(i_rs2_d),
    .i_rs1_used_d(i_rs1_used_d), .i_rs2_used_d(i_rs2_used_d),
    .i_rd_e(i_rd_e), .i_w_en_e(i_w_en_e), .i_mem_rd_e(i_mem_rd_e),
    .i_mc_start_e(i_mc_start_e), .i_mc_done(i_mc_done),
    .i_branch_taken_e(i_branch_taken_e),
    .o_stall_f(o_stall_f), .o_stall_d(o_stall_d), .o_stall_e(o_stall_e),
    .o_flush_d(o_flush_d), .o_flush_e(o_flush_e), .o_flush_m(o_flush_m),
    .o_mc_go(o_mc_go), .o_mc_err(o_mc_err),
    .o_state(o_state), .o_stall_cnt(o_stall_cnt)
  );

  // Clock and reset
  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  initial begin
    i_rst = 1'b1;
    i_rs1_d = '0; i_rs2_d = '0; i_rd_e = '0;
    i_rs1_used_d = 1'b0; i_rs2_used_d = 1'b0;
    i_w_en_e = 1'b0; i_mem_rd_e = 1'b0; i_mc_start_e = 1'b0;
    i_mc_done = 1'b0; i_branch_taken_e = 1'b0;
  end

  function automatic stim_t idle();
    stim_t s;
    s = '0;
    return s;
  endfunction

  function automatic stim_t load_use_rs2(input logic [4:0] r);
    stim_t s;
    s = '0;
    s.rd = r; s.w_en = 1'b1; s.mem_rd = 1'b1;
    s.rs2 = r; s.rs2_used = 1'b1; s.rs1 = 5'd1;
    return s;
  endfunction

  // Reference model: apply the pipeline rules for one cycle, push the
  // outputs expected during that cycle, then advance to the next cycle.
  task automatic model_cycle(input stim_t s);
    bit sf, sd, se, fd, fe, fm, lu, done_ok, next_go;
    sf = 0; sd = 0; se = 0; fd = 0; fe = 0; fm = 0;
    lu = s.mem_rd && s.w_en && (s.rd != 0) &&
         ((s.rs1_used && s.rs1 == s.rd) || (s.rs2_used && s.rs2 == s.rd));
    done_ok = (m_mode == 1) && s.mc_done && !m_go;
    if (!s.rst) begin
      if (m_mode == 0) begin
        if (s.mc_start)    begin sf = 1; sd = 1; se = 1; fm = 1; end
        else if (s.branch) begin fd = 1; fe = 1; end
        else if (lu)       begin sf = 1; sd = 1; fe = 1; end
      end else if (m_mode == 1) begin
        if (!done_ok) begin sf = 1; sd = 1; se = 1; fm = 1; end
      end else begin
        sf = 1; sd = 1; se = 1; fm = 1;
      end
    end
    exp_q.push_back({sf, sd, se, fd, fe, fm, m_go, m_err, 2'(m_mode), 16'(m_stalls)});

    if (s.rst) begin
      m_mode = 0; m_waited = 0; m_go = 0; m_err = 0; m_stalls = 0;
    end else begin
      if (sf && m_stalls < 65535) m_stalls++;
      next_go = (m_mode == 0) && s.mc_start;
      if (m_mode == 0) begin
        if (s.mc_start) begin m_mode = 1; m_waited = 0; end
      end else if (m_mode == 1) begin
        if (done_ok) m_mode = 0;
        else begin
          m_waited++;
          if (m_waited == TIMEOUT) begin m_mode = 2; m_err = 1; end
        end
      end
      m_go = next_go;
    end
  endtask

  // Driver
  task automatic drive(input stim_t s);
    @(posedge i_clk);
    #1;
    i_rst = s.rst;
    i_rs1_d = s.rs1; i_rs2_d = s.rs2; i_rd_e = s.rd;
    i_rs1_used_d = s.rs1_used; i_rs2_used_d = s.rs2_used;
    i_w_en_e = s.w_en; i_mem_rd_e = s.mem_rd;
    i_mc_start_e = s.mc_start; i_mc_done = s.mc_done;
    i_branch_taken_e = s.branch;
    model_cycle(s);
  endtask

  task automatic drive_idle(input int n);
    for (int k = 0; k < n; k++) drive(idle());
  endtask

  // Scoreboard monitor
  initial begin
    logic [W-1:0] exp_v, got_v;
    forever begin
      @(negedge i_clk);
      cyc++;
      if (exp_q.size() > 0) begin
        exp_v = exp_q.pop_front();
        got_v = {o_stall_f, o_stall_d, o_stall_e, o_flush_d, o_flush_e,
                 o_flush_m, o_mc_go, o_mc_err, o_state, o_stall_cnt};
        n_checks++;
        if (got_v !== exp_v) begin
          n_fail++;
          $display("FAIL outputs cycle %0d: got stall_fde=%b flush_dem=%b go=%b err=%b state=%0d cnt=%0d, required stall_fde=%b flush_dem=%b go=%b err=%b state=%0d cnt=%0d",
                   cyc, got_v[25:23], got_v[22:20], got_v[19], got_v[18], got_v[17:16], got_v[15:0],
                   exp_v[25:23], exp_v[22:20], exp_v[19], exp_v[18], exp_v[17:16], exp_v[15:0]);
        end
      end
    end
  end

  // Stimulus
  initial begin
    stim_t s;
    int waited;

    s = idle(); s.rst = 1'b1;
    drive(s);
    drive_idle(2);

    // Load-use on rs2, then the stall count becomes visible.
    drive(load_use_rs2(5'd5));
    drive_idle(1);

    // No hazard: destination x0, or rs2 not used.
    s = load_use_rs2(5'd0); drive(s);
    s = load_use_rs2(5'd5); s.rs2_used = 1'b0; drive(s);

    // Branch overrides load-use.
    s = load_use_rs2(5'd5); s.branch = 1'b1; drive(s);
    drive_idle(1);

    // Multi-cycle op with done five cycles after go.
    s = idle(); s.mc_start = 1'b1; drive(s);
    drive_idle(5);
    s = idle(); s.mc_done = 1'b1; drive(s);
    drive_idle(2);

    // Done coincident with go is ignored; a later done completes.
    s = load_use_rs2(5'd7); s.mc_start = 1'b1; s.branch = 1'b1; drive(s);
    s = idle(); s.mc_done = 1'b1; drive(s);
    drive_idle(2);
    s = idle(); s.mc_done = 1'b1; drive(s);
    drive_idle(1);

    // Timeout into MC_ERR, sticky against done/branch, then reset.
    s = idle(); s.mc_start = 1'b1; drive(s);
    drive_idle(TIMEOUT);
    s = idle(); s.mc_done = 1'b1; s.branch = 1'b1; drive(s);
    drive_idle(2);
    s = idle(); s.rst = 1'b1; drive(s);
    drive_idle(2);

    // Reset during MC_WAIT abandons the operation.
    s = idle(); s.mc_start = 1'b1; drive(s);
    drive_idle(2);
    s = idle(); s.rst = 1'b1; drive(s);
    drive_idle(2);

    // Random traffic over a small register set so hazards are frequent.
    for (int n = 0; n < 800; n++) begin
      s = '0;
      s.rst      = ($urandom_range(0, 39) == 0);
      s.rs1      = 5'($urandom_range(0, 3));
      s.rs2      = 5'($urandom_range(0, 3));
      s.rd       = 5'($urandom_range(0, 3));
      s.rs1_used = 1'($urandom_range(0, 1));
      s.rs2_used = 1'($urandom_range(0, 1));
      s.w_en     = 1'($urandom_range(0, 1));
      s.mem_rd   = ($urandom_range(0, 2) != 0);
      s.mc_start = ($urandom_range(0, 9) == 0);
      s.mc_done  = ($urandom_range(0, 5) == 0);
      s.branch   = ($urandom_range(0, 5) == 0);
      drive(s);
    end

    // Drain with a bounded wait.
    waited = 0;
    while (exp_q.size() > 0 && waited < 10) begin
      @(posedge i_clk);
      waited++;
    end
    #1;
    if (exp_q.size() > 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
